// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I pipeline types used by the MEM/WB boundary
package rv32i_types;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wbsel_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       load_regfile;
        logic [2:0] funct3;
        wbsel_t     wbsel;
    } rv32i_control_word;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } mem_wb_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - MEM-side inputs and WB-side outputs of the MEM/WB boundary
interface mem_wb_stage_if;
    import rv32i_types::*;

    logic              MEM_valid;
    rv32i_control_word MEM_ctrl;
    logic [4:0]        MEM_rd;
    logic [31:0]       MEM_pc;
    logic [31:0]       MEM_alu_out;
    logic [31:0]       MEM_data_read;
    logic              data_resp;
    logic              pipe_freeze;

    logic              mem_stall;
    logic              access_done;
    logic              WB_valid;
    logic              WB_load_regfile;
    logic [4:0]        WB_rd;
    logic [31:0]       WB_data;
    logic [31:0]       WB_pc;

    modport master (
        output MEM_valid, MEM_ctrl, MEM_rd, MEM_pc, MEM_alu_out, MEM_data_read,
               data_resp, pipe_freeze,
        input  mem_stall, access_done, WB_valid, WB_load_regfile, WB_rd, WB_data, WB_pc
    );

    modport slave (
        input  MEM_valid, MEM_ctrl, MEM_rd, MEM_pc, MEM_alu_out, MEM_data_read,
               data_resp, pipe_freeze,
        output mem_stall, access_done, WB_valid, WB_load_regfile, WB_rd, WB_data, WB_pc
    );

endinterface

// File: rtl/load_formatter.sv
// rtl/load_formatter.sv - selects and extends the loaded byte/halfword/word
module load_formatter
    import rv32i_types::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] word_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[8*offset_i +: 8];
        // Halfword accesses are assumed aligned; offset bit 0 is deliberately ignored.
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        result_o = word_i;
        unique case (funct3_i)
            LB:      result_o = {{24{byte_sel[7]}}, byte_sel};
            LBU:     result_o = {24'd0, byte_sel};
            LH:      result_o = {{16{half_sel[15]}}, half_sel};
            LHU:     result_o = {16'd0, half_sel};
            LW:      result_o = word_i;
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB boundary: data-memory handshake, freeze capture, writeback regs
module mem_wb_stage
    import rv32i_types::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  bus
);

    mem_wb_state_t   state_q, state_d;
    logic [XLEN-1:0] buffer_q, buffer_d;
    logic            wb_valid_q, wb_valid_d;
    logic            wb_lrf_q, wb_lrf_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [XLEN-1:0] wb_pc_q, wb_pc_d;

    logic            acc;
    logic            stall;
    logic            advance;
    logic [XLEN-1:0] load_word;
    logic [XLEN-1:0] load_fmt;

    assign acc     = bus.MEM_valid & (bus.MEM_ctrl.mem_read | bus.MEM_ctrl.mem_write);
    assign stall   = acc & ~bus.data_resp & (state_q == IDLE);
    assign advance = ~bus.pipe_freeze & ~stall;

    // Once the response has been captured, the live memory bus may already show another word.
    assign load_word = (state_q == HOLD) ? buffer_q : bus.MEM_data_read;

    load_formatter u_load_formatter (
        .funct3_i (bus.MEM_ctrl.funct3),
        .offset_i (bus.MEM_alu_out[1:0]),
        .word_i   (load_word),
        .result_o (load_fmt)
    );

    always_comb begin
        state_d  = state_q;
        buffer_d = buffer_q;
        unique case (state_q)
            IDLE: begin
                if (acc & bus.data_resp & bus.pipe_freeze) begin
                    state_d  = HOLD;
                    buffer_d = bus.MEM_data_read;
                end
            end
            HOLD: begin
                if (~bus.pipe_freeze) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_lrf_d   = wb_lrf_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_pc_d    = wb_pc_q;
        if (advance) begin
            wb_valid_d = bus.MEM_valid;
            wb_lrf_d   = bus.MEM_valid & bus.MEM_ctrl.load_regfile & (bus.MEM_rd != 5'd0);
            wb_rd_d    = bus.MEM_rd;
            wb_pc_d    = bus.MEM_pc;
            unique case (bus.MEM_ctrl.wbsel)
                WB_ALU:  wb_data_d = bus.MEM_alu_out;
                WB_LOAD: wb_data_d = load_fmt;
                WB_PC4:  wb_data_d = bus.MEM_pc + 32'd4;
                default: wb_data_d = bus.MEM_alu_out;
            endcase
        end else if (~bus.pipe_freeze) begin
            wb_valid_d = 1'b0;
            wb_lrf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            buffer_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_lrf_q   <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
            wb_pc_q    <= RESET_PC;
        end else begin
            state_q    <= state_d;
            buffer_q   <= buffer_d;
            wb_valid_q <= wb_valid_d;
            wb_lrf_q   <= wb_lrf_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_pc_q    <= wb_pc_d;
        end
    end

    assign bus.mem_stall       = stall;
    assign bus.access_done     = (state_q == HOLD);
    assign bus.WB_valid        = wb_valid_q;
    assign bus.WB_load_regfile = wb_lrf_q;
    assign bus.WB_rd           = wb_rd_q;
    assign bus.WB_data         = wb_data_q;
    assign bus.WB_pc           = wb_pc_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference: a captured-response flag plus the word captured, and the expected WB regs.
    bit          m_captured;
    logic [31:0] m_word;
    bit          m_adv;
    logic        e_valid, e_lrf;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_pc;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        m_captured = 0; m_word = 0; m_adv = 1;
        e_valid = 0; e_lrf = 0; e_rd = 0; e_data = 0; e_pc = 0;
    endtask

    task automatic set_in(input bit v, input bit rd_, input bit wr, input bit lrf,
                          input logic [2:0] f3, input wbsel_t ws, input logic [4:0] rd,
                          input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] dr,
                          input bit resp, input bit frz);
        bus.MEM_valid              = v;
        bus.MEM_ctrl.mem_read      = rd_;
        bus.MEM_ctrl.mem_write     = wr;
        bus.MEM_ctrl.load_regfile  = lrf;
        bus.MEM_ctrl.funct3        = f3;
        bus.MEM_ctrl.wbsel         = ws;
        bus.MEM_rd                 = rd;
        bus.MEM_pc                 = pc;
        bus.MEM_alu_out            = alu;
        bus.MEM_data_read          = dr;
        bus.data_resp              = resp;
        bus.pipe_freeze            = frz;
    endtask

    // One clock: compare combinational outputs mid-cycle, advance reference, compare WB regs.
    task automatic cycle();
        bit          acc, exp_stall, go;
        logic [31:0] w, wbv;
        @(negedge clk);
        acc       = bus.MEM_valid && (bus.MEM_ctrl.mem_read || bus.MEM_ctrl.mem_write);
        exp_stall = acc && !bus.data_resp && !m_captured;
        checks++;
        if (bus.mem_stall !== exp_stall) begin
            errors++; $display("FAIL mem_stall got %b exp %b", bus.mem_stall, exp_stall);
        end
        checks++;
        if (bus.access_done !== m_captured) begin
            errors++; $display("FAIL access_done got %b exp %b", bus.access_done, m_captured);
        end
        w  = m_captured ? m_word : bus.MEM_data_read;
        go = !bus.pipe_freeze && !exp_stall;
        if (go) begin
            case (bus.MEM_ctrl.wbsel)
                WB_LOAD: wbv = ref_load(bus.MEM_ctrl.funct3, bus.MEM_alu_out[1:0], w);
                WB_PC4:  wbv = bus.MEM_pc + 32'd4;
                default: wbv = bus.MEM_alu_out;
            endcase
            e_valid = bus.MEM_valid;
            e_lrf   = bus.MEM_valid && bus.MEM_ctrl.load_regfile && (bus.MEM_rd != 0);
            e_rd    = bus.MEM_rd;
            e_pc    = bus.MEM_pc;
            e_data  = wbv;
        end else if (!bus.pipe_freeze) begin
            e_valid = 0; e_lrf = 0;
        end
        if (!m_captured && acc && bus.data_resp && bus.pipe_freeze) begin
            m_captured = 1; m_word = bus.MEM_data_read;
        end else if (m_captured && !bus.pipe_freeze) begin
            m_captured = 0;
        end
        m_adv = go;
        @(posedge clk); #1;
        checks++;
        if ({bus.WB_valid, bus.WB_load_regfile, bus.WB_rd} !== {e_valid, e_lrf, e_rd}) begin
            errors++;
            $display("FAIL wb_ctl got v=%b we=%b rd=%0d exp v=%b we=%b rd=%0d", bus.WB_valid,
                     bus.WB_load_regfile, bus.WB_rd, e_valid, e_lrf, e_rd);
        end
        checks++;
        if ({bus.WB_data, bus.WB_pc} !== {e_data, e_pc}) begin
            errors++;
            $display("FAIL wb_dat got data=%h pc=%h exp data=%h pc=%h", bus.WB_data, bus.WB_pc,
                     e_data, e_pc);
        end
    endtask

    task automatic idle_in();
        set_in(0, 0, 0, 0, LW, WB_ALU, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_in();
        model_reset();
        @(posedge clk); #1;
        checks++;
        if ({bus.WB_valid, bus.WB_load_regfile, bus.WB_rd, bus.WB_data, bus.WB_pc, bus.access_done}
            !== {1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0}) begin
            errors++; $display("FAIL reset_state got v=%b we=%b rd=%0d d=%h pc=%h done=%b",
                bus.WB_valid, bus.WB_load_regfile, bus.WB_rd, bus.WB_data, bus.WB_pc,
                bus.access_done);
        end
        rst = 1'b1;
    endtask

    task automatic test_alu();
        set_in(1, 0, 0, 1, 3'b000, WB_ALU, 5, 32'h100, 32'h1234, 32'h0, 0, 0);
        cycle();
        checks++;
        if ({bus.WB_data, bus.WB_rd, bus.WB_load_regfile} !== {32'h1234, 5'd5, 1'b1}) begin
            errors++; $display("FAIL alu_op got d=%h rd=%0d we=%b exp d=00001234 rd=5 we=1",
                               bus.WB_data, bus.WB_rd, bus.WB_load_regfile);
        end
    endtask

    task automatic test_lb_stall();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 0, 1, LB, WB_LOAD, 7, 32'h104, 32'h1003, 32'h0, 0, 0);
            cycle();
            checks++;
            if (bus.WB_valid !== 1'b0) begin
                errors++; $display("FAIL lb_bubble got %b exp 0", bus.WB_valid);
            end
        end
        set_in(1, 1, 0, 1, LB, WB_LOAD, 7, 32'h104, 32'h1003, 32'h80FF_7F01, 1, 0);
        cycle();
        checks++;
        if (bus.WB_data !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL lb_sign got %h exp ffffff80", bus.WB_data);
        end
    endtask

    task automatic test_lhu();
        logic [31:0] offs [2];
        offs[0] = 32'h1002; offs[1] = 32'h1003;
        for (int i = 0; i < 2; i++) begin
            set_in(1, 1, 0, 1, LHU, WB_LOAD, 8, 32'h108, offs[i], 32'h80FF_7F01, 1, 0);
            cycle();
            checks++;
            if (bus.WB_data !== 32'h0000_80FF) begin
                errors++; $display("FAIL lhu_off%0d got %h exp 000080ff", i, bus.WB_data);
            end
        end
    endtask

    task automatic test_freeze_capture();
        set_in(1, 1, 0, 1, LW, WB_LOAD, 9, 32'h10C, 32'h2000, 32'h1234_5678, 1, 1);
        cycle();
        for (int i = 0; i < 2; i++) begin
            set_in(1, 1, 0, 1, LW, WB_LOAD, 9, 32'h10C, 32'h2000, 32'hDEAD_BEEF, 0, 1);
            #1;
            checks++;
            if ({bus.access_done, bus.mem_stall} !== 2'b10) begin
                errors++; $display("FAIL hold_flags got done=%b stall=%b exp done=1 stall=0",
                                   bus.access_done, bus.mem_stall);
            end
            cycle();
        end
        set_in(1, 1, 0, 1, LW, WB_LOAD, 9, 32'h10C, 32'h2000, 32'hDEAD_BEEF, 0, 0);
        cycle();
        checks++;
        if (bus.WB_data !== 32'h1234_5678) begin
            errors++; $display("FAIL freeze_capture got %h exp 12345678", bus.WB_data);
        end
    endtask

    task automatic test_x0_jal_store();
        set_in(1, 1, 0, 1, LW, WB_LOAD, 0, 32'h110, 32'h3000, 32'h5555_AAAA, 1, 0);
        cycle();
        checks++;
        if ({bus.WB_valid, bus.WB_load_regfile} !== 2'b10) begin
            errors++; $display("FAIL x0_load got v=%b we=%b exp v=1 we=0",
                               bus.WB_valid, bus.WB_load_regfile);
        end
        set_in(1, 0, 1, 0, LW, WB_ALU, 3, 32'h114, 32'h3004, 32'h0, 1, 0);
        cycle();
        checks++;
        if ({bus.WB_valid, bus.WB_load_regfile} !== 2'b10) begin
            errors++; $display("FAIL store got v=%b we=%b exp v=1 we=0",
                               bus.WB_valid, bus.WB_load_regfile);
        end
        set_in(1, 0, 0, 1, 3'b000, WB_PC4, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0);
        cycle();
        checks++;
        if (bus.WB_data !== 32'h0) begin
            errors++; $display("FAIL jal_wrap got %h exp 00000000", bus.WB_data);
        end
    endtask

    task automatic test_random();
        logic [2:0] f3s [6];
        bit v, rd_, wr, lrf;
        logic [2:0] f3;
        wbsel_t ws;
        logic [4:0] rd;
        logic [31:0] pc, alu;
        f3s[0] = LB; f3s[1] = LH; f3s[2] = LW; f3s[3] = LBU; f3s[4] = LHU; f3s[5] = 3'b011;
        v = 0; rd_ = 0; wr = 0; lrf = 0; f3 = LW; ws = WB_ALU; rd = 0; pc = 0; alu = 0;
        for (int n = 0; n < 400; n++) begin
            if (m_adv) begin
                v   = ($urandom_range(0, 4) != 0);
                rd_ = $urandom_range(0, 1);
                wr  = !rd_ && ($urandom_range(0, 2) == 0);
                lrf = !wr && ($urandom_range(0, 3) != 0);
                f3  = f3s[$urandom_range(0, 5)];
                ws  = wbsel_t'($urandom_range(0, 2));
                rd  = 5'($urandom_range(0, 31));
                pc  = $urandom;
                alu = $urandom;
            end
            set_in(v, rd_, wr, lrf, f3, ws, rd, pc, alu, $urandom,
                   $urandom_range(0, 1), ($urandom_range(0, 9) < 3));
            cycle();
        end
    endtask

    task automatic test_async_reset();
        set_in(1, 1, 0, 1, LW, WB_LOAD, 4, 32'h200, 32'h4000, 32'hCAFE_F00D, 1, 1);
        cycle();
        checks++;
        if (bus.access_done !== 1'b1) begin
            errors++; $display("FAIL enter_hold got %b exp 1", bus.access_done);
        end
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({bus.WB_valid, bus.WB_load_regfile, bus.WB_rd, bus.WB_data, bus.WB_pc, bus.access_done}
            !== {1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0}) begin
            errors++; $display("FAIL async_reset got v=%b we=%b rd=%0d d=%h pc=%h done=%b",
                bus.WB_valid, bus.WB_load_regfile, bus.WB_rd, bus.WB_data, bus.WB_pc,
                bus.access_done);
        end
        idle_in();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        set_in(1, 0, 0, 1, 3'b000, WB_ALU, 12, 32'h300, 32'h0000_0ABC, 32'h0, 0, 0);
        cycle();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb_stall();
        test_lhu();
        test_freeze_capture();
        test_x0_jal_store();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline boundary directly downstream of the MEM stage. Completes the data-memory handshake and raises a stall while a load/store is outstanding. Holds returned read data across freezes caused by other hazards. Formats load data (lb/lh/lw/lbu/lhu) and registers the final writeback value, rd and regfile write-enable for the regfile and forwarding unit.

Parameters:
XLEN, 32, datapath width; only 32 supported.
RESET_PC, 32'h0000_0000, reset value of WB_pc.

Ports:
clk  in  1  clock; all state on rising edge.
rst  in  1  reset; one clock; reset is asynchronous and active-low.
MEM_valid  in  1  MEM slot holds a real instruction, not a bubble.
MEM_ctrl  in  rv32i_control_word  uses mem_read, mem_write, load_regfile, funct3, wbsel.
MEM_rd  in  5  destination register.
MEM_pc  in  32  instruction PC.
MEM_alu_out  in  32  ALU result / unaligned memory address.
MEM_data_read  in  32  raw word from data memory.
data_resp  in  1  data memory completed the current access.
pipe_freeze  in  1  freeze request from other hazard sources (I-side miss etc.).
mem_stall  out  1  MEM access outstanding; hazard unit freezes IF..MEM.
access_done  out  1  current MEM access already completed; MEM gates data_read/data_write with ~access_done.
WB_valid  out  1  WB slot valid.
WB_load_regfile  out  1  regfile write enable.
WB_rd  out  5  destination register.
WB_data  out  32  writeback value.
WB_pc  out  32  PC of WB instruction.

Behaviour:
- Reset (rst low, async): state=IDLE, buffer=0, WB_valid=0, WB_load_regfile=0, WB_rd=0, WB_data=0, WB_pc=RESET_PC.
- acc = MEM_valid & (mem_read | mem_write).
- mem_stall = acc & ~data_resp & (state==IDLE); combinational. Zero in HOLD.
- access_done = (state==HOLD); registered, glitch-free.
- FSM:
  - IDLE -> HOLD when acc & data_resp & pipe_freeze. Latch MEM_data_read into buffer on that edge.
  - HOLD -> IDLE when ~pipe_freeze.
  - HOLD ignores data_resp.
- Load data source: buffer in HOLD, else MEM_data_read.
- advance = ~pipe_freeze & ~mem_stall.
- On advance, WB regs load from MEM (1-cycle latency):
  - WB_valid <= MEM_valid.
  - WB_load_regfile <= MEM_valid & load_regfile & (MEM_rd != 0).
- On pipe_freeze: all WB regs hold.
- On mem_stall & ~pipe_freeze: WB_valid <= 0 and WB_load_regfile <= 0 (bubble); other WB regs hold.
- wbsel selects WB_data:
  - WB_ALU: MEM_alu_out.
  - WB_LOAD: formatted load.
  - WB_PC4: MEM_pc + 4, modulo 2^32.
- Load formatting, off = MEM_alu_out[1:0]:
  - lb/lbu: byte off, sign-/zero-extended.
  - lh/lhu: halfword off[1], off[0] ignored.
  - lw: full word, off ignored.
  - Other funct3 with WB_LOAD: full word.
- Stores (mem_write, load_regfile=0) traverse WB with WB_valid=1 and write enable 0.
- Simultaneous data_resp and ~pipe_freeze in IDLE: advance the same cycle, no HOLD.
- Reset mid-HOLD: returns to IDLE. An in-flight access is abandoned; the memory side is reset by the same rst.

Decomposition:
- rv32i_types package gains:
  - wbsel_t enum, 2 bits: WB_ALU=0, WB_LOAD=1, WB_PC4=2.
  - wbsel field in rv32i_control_word.
  - mem_wb_state_t enum: IDLE, HOLD.
  - funct3 load constants: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- Sub-module load_formatter: purely combinational (funct3, offset, word -> 32-bit result). Unit-tested separately.

Test Plan:
- ALU op: MEM_valid=1, wbsel=WB_ALU, alu_out=0x1234, rd=5, no freeze -> next cycle WB_data=0x1234, WB_rd=5, WB_load_regfile=1.
- lb sign: word 0x80FF_7F01, alu_out=0x1003, funct3=LB, data_resp after 3 cycles -> mem_stall high 3 cycles, WB bubbles, then WB_data=0xFFFF_FF80.
- lhu: same word, alu_out=0x1002, LHU, resp immediate -> WB_data=0x0000_80FF. Same with alu_out=0x1003 -> identical.
- Freeze capture: lw with resp in a pipe_freeze cycle, MEM_data_read changes to 0xDEAD_BEEF next cycle, freeze held 2 more cycles -> access_done=1 for those cycles, mem_stall=0, WB_data=original word after release.
- rd=x0 load -> WB_valid=1, WB_load_regfile=0. jal wbsel=WB_PC4, pc=0xFFFF_FFFC -> WB_data=0.
- Async reset asserted mid-HOLD, between clock edges -> all outputs reset values immediately, access_done=0.
